pipelined_csel_adder: RTL and testbench
=======================================

PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter BLK, default 8: carry-select block width in bits; NBLK = WIDTH/BLK blocks and pipeline stages.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: operand beat offered.
REQ-006 Port in_ready, output, 1: block accepts the beat this cycle.
REQ-007 Port a, input, WIDTH: operand A.
REQ-008 Port b, input, WIDTH: operand B.
REQ-009 Port cin, input, 1: carry in; used only in add mode.
REQ-010 Port sub, input, 1: 0 = add (a+b+cin), 1 = subtract (a-b, computed as a+~b+1, cin ignored).
REQ-011 Port out_valid, output, 1: result beat valid.
REQ-012 Port out_ready, input, 1: downstream accepts the result.
REQ-013 Port sum, output, WIDTH: result bits [WIDTH-1:0].
REQ-014 Port cout, output, 1: carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-015 Port ovf, output, 1: two's-complement signed overflow of the operation.

Function
REQ-016 WIDTH SHALL be a positive multiple of BLK, and BLK SHALL be >= 1; otherwise elaboration fails via a static check.
REQ-017 A beat is accepted on a cycle with in_valid && in_ready; a result is consumed on a cycle with out_valid && out_ready.
REQ-018 Stage 0 ripple-adds block 0 with carry-in = (sub ? 1 : cin) and registers the block-0 sum bits, the block-0 carry, the remaining operand bits (B already conditionally inverted), and a valid bit.
REQ-019 Stage k (1..NBLK-1) computes block k twice, once with carry-in 0 and once with carry-in 1, from the registered operands.
REQ-020 Stage k selects the sum and carry pair using the carry registered by stage k-1, then registers the accumulated sum bits, the carry, and the remaining operands.
REQ-021 Latency from acceptance to out_valid SHALL be exactly NBLK cycles when out_ready is held high.
REQ-022 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-023 sum, cout and ovf SHALL be driven from the final stage register.
REQ-024 ovf = carry into bit WIDTH-1 XOR cout, with both taken from the final block.
REQ-025 Backpressure: the pipeline SHALL advance when out_ready || !out_valid; otherwise every stage holds its contents.
REQ-026 in_ready = out_ready || !out_valid.
REQ-027 Bubbles (valid = 0 stages) SHALL be squeezed: a stage whose own valid is 0 loads from its predecessor even while the pipeline stalls downstream.
REQ-028 in_ready SHALL then also be 1 whenever stage 0 is empty.
REQ-029 A held (stalled) result SHALL keep sum, cout and ovf stable until consumed.
REQ-030 Wrap-around: results are modulo 2^WIDTH, and the carry appears only on cout.
REQ-031 Simultaneous accept and consume in one cycle SHALL lose no beat and duplicate no beat.
REQ-032 Results SHALL emerge in acceptance order.
REQ-033 in_ready SHALL NOT combinationally depend on in_valid.

Reset
REQ-034 While rst = 1, all stage valid bits SHALL be 0, so out_valid = 0.
REQ-035 While rst = 1, sum = 0, cout = 0 and ovf = 0.
REQ-036 While rst = 1, in_ready SHALL be 1.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight beats immediately, without waiting for a clock edge.
REQ-038 The first beat accepted after rst deasserts SHALL be the first result produced.

Verification (WIDTH=16, BLK=4, latency 4)
REQ-039 Add with carry across every block: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
REQ-040 Signed overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1.
REQ-041 Subtract: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-042 Back-to-back beats with out_ready=1: 8 consecutive beats (a=i, b=i) -> results 2i appear on 8 consecutive cycles, starting 4 cycles after the first beat.
REQ-043 Backpressure: with the pipe full, out_ready=0 for 3 cycles -> in_ready=0, outputs frozen; on release all beats drain in order with none lost.
REQ-044 Reset mid-flight: 3 beats in flight, pulse rst between clock edges -> out_valid=0 at once; after release, a new beat a=0x1234, b=0x1111 -> sum=0x2345 after 4 cycles, with no stale beats.

Source files
------------

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one BLK-bit block resolved per stage,
// valid/ready handshake with bubble squeezing and full-throughput streaming.
module pipelined_csel_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int BLK_SAFE = (BLK >= 1) ? BLK : 1;
    localparam int NBLK     = (WIDTH >= BLK_SAFE) ? WIDTH / BLK_SAFE : 1;

    generate
        if (BLK < 1 || WIDTH < BLK_SAFE || (WIDTH % BLK_SAFE) != 0) begin : g_bad_params
            $error("pipelined_csel_adder: WIDTH must be a positive multiple of BLK, BLK >= 1");
        end
    endgenerate

    // Returns {carry into block msb, carry out, block sum}.
    function automatic logic [BLK_SAFE+1:0] blk_add(input logic [BLK_SAFE-1:0] x,
                                                    input logic [BLK_SAFE-1:0] y,
                                                    input logic                c);
        logic [BLK_SAFE:0] t;
        t = {1'b0, x} + {1'b0, y} + {{BLK_SAFE{1'b0}}, c};
        return {t[BLK_SAFE-1] ^ x[BLK_SAFE-1] ^ y[BLK_SAFE-1], t};
    endfunction

    logic [NBLK-1:0]  vld_q, vld_d, en;
    logic [WIDTH-1:0] a_q  [NBLK];
    logic [WIDTH-1:0] a_d  [NBLK];
    logic [WIDTH-1:0] bx_q [NBLK];
    logic [WIDTH-1:0] bx_d [NBLK];
    logic [WIDTH-1:0] s_q  [NBLK];
    logic [WIDTH-1:0] s_d  [NBLK];
    logic             c_q  [NBLK];
    logic             c_d  [NBLK];
    logic             cm_q [NBLK];
    logic             cm_d [NBLK];

    // A stage may load when it is empty or when every stage below it can move.
    always_comb begin
        en = '0;
        for (int k = 0; k < NBLK; k++) begin
            en[k] = out_ready;
            for (int j = k; j < NBLK; j++) begin
                en[k] = en[k] | ~vld_q[j];
            end
        end
    end

    always_comb begin
        logic [WIDTH-1:0]    bx_in;
        logic [BLK_SAFE-1:0] x, y;
        logic [BLK_SAFE+1:0] r0, r1, r;
        bx_in = sub ? ~b : b;
        x     = '0;
        y     = '0;
        r0    = '0;
        r1    = '0;
        r     = blk_add(a[BLK_SAFE-1:0], bx_in[BLK_SAFE-1:0], sub | cin);

        vld_d[0]                = in_valid;
        a_d[0]                  = a;
        bx_d[0]                 = bx_in;
        s_d[0]                  = '0;
        s_d[0][BLK_SAFE-1:0]    = r[BLK_SAFE-1:0];
        c_d[0]                  = r[BLK_SAFE];
        cm_d[0]                 = r[BLK_SAFE+1];

        for (int k = 1; k < NBLK; k++) begin
            x  = a_q[k-1][k*BLK_SAFE +: BLK_SAFE];
            y  = bx_q[k-1][k*BLK_SAFE +: BLK_SAFE];
            r0 = blk_add(x, y, 1'b0);
            r1 = blk_add(x, y, 1'b1);
            r  = c_q[k-1] ? r1 : r0;

            vld_d[k]                        = vld_q[k-1];
            a_d[k]                          = a_q[k-1];
            bx_d[k]                         = bx_q[k-1];
            s_d[k]                          = s_q[k-1];
            s_d[k][k*BLK_SAFE +: BLK_SAFE]  = r[BLK_SAFE-1:0];
            c_d[k]                          = r[BLK_SAFE];
            cm_d[k]                         = r[BLK_SAFE+1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < NBLK; k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
                cm_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NBLK; k++) begin
                if (en[k]) begin
                    vld_q[k] <= vld_d[k];
                    a_q[k]   <= a_d[k];
                    bx_q[k]  <= bx_d[k];
                    s_q[k]   <= s_d[k];
                    c_q[k]   <= c_d[k];
                    cm_q[k]  <= cm_d[k];
                end
            end
        end
    end

    assign in_ready  = en[0];
    assign out_valid = vld_q[NBLK-1];
    assign sum       = s_q[NBLK-1];
    assign cout      = c_q[NBLK-1];
    assign ovf       = cm_q[NBLK-1] ^ c_q[NBLK-1];

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder (WIDTH=16, BLK=4): scoreboard queue filled at
// acceptance, drained by an output monitor; scenario tasks add their own checks.
module tb_pipelined_csel_adder;

    localparam int W = 16;
    localparam int B = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    logic [W+1:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_csel_adder #(.WIDTH(W), .BLK(B)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Reference: {ovf, cout, sum} from wide arithmetic and the sign rule.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        logic [W:0]   t;
        logic [W-1:0] yy;
        logic         o;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? 1'b1 : c)};
        o  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        return {o, t[W], t[W-1:0]};
    endfunction

    // One cycle: drive just after the falling edge, record an accepted beat.
    task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s, input logic ordy);
        @(negedge clk);
        #1;
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = c;
        sub       = s;
        out_ready = ordy;
        #1;
        if (v && in_ready && !rst) exp_q.push_back(model(x, y, c, s));
    endtask

    always @(negedge clk) begin
        logic [W+1:0] e;
        #2;
        if (!rst && out_valid && out_ready) begin
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result got sum=%h cout=%b ovf=%b required no result", sum, cout, ovf);
            end else begin
                e = exp_q.pop_front();
                if ({ovf, cout, sum} !== e) begin
                    failures++;
                    $display("FAIL result got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                             sum, cout, ovf, e[W-1:0], e[W], e[W+1]);
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain got pending=%0d out_valid=%b required 0 and 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
        checks++;
        if ({ovf, cout, sum} !== '0) begin
            failures++; $display("FAIL rst_outputs got sum=%h cout=%b ovf=%b required all 0", sum, cout, ovf);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_directed(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s, input string name);
        int lat;
        lat = -1;
        step(1'b1, x, y, c, s, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (out_valid === 1'b1) begin lat = k; break; end
        end
        checks++;
        if (lat != 4) begin failures++; $display("FAIL latency_%s got %0d required 4", name, lat); end
        drain();
    endtask

    task automatic test_back_to_back();
        int first, last, cnt;
        first = -1; last = -1; cnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            step(cyc < 8, W'(cyc), W'(cyc), 1'b0, 1'b0, 1'b1);
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
                cnt++;
            end
        end
        checks++;
        if (first != 4 || last != 11 || cnt != 8) begin
            failures++;
            $display("FAIL b2b_timing got first=%0d last=%0d count=%0d required 4 11 8", first, last, cnt);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int accepted;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, W'(16'h1000 + i * 16'h0101), W'(16'h0F00 - i), 1'b1, i[0], 1'b0);
        end
        accepted = exp_q.size();
        checks++;
        if (accepted != 4) begin failures++; $display("FAIL bp_fill got %0d required 4", accepted); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_stall got in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
            end
            checks++;
            if (exp_q.size() == 0 || {ovf, cout, sum} !== exp_q[0]) begin
                failures++;
                $display("FAIL bp_frozen got sum=%h cout=%b ovf=%b required head of queue", sum, cout, ovf);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        int n0, lat;
        lat = -1;
        for (int i = 0; i < 3; i++) step(1'b1, W'(16'h0100 * (i + 1)), 16'h0003, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {ovf, cout, sum} !== '0) begin
            failures++;
            $display("FAIL midrst_async got out_valid=%b in_ready=%b sum=%h required 0 1 0000",
                     out_valid, in_ready, sum);
        end
        exp_q.delete();
        #1 rst = 1'b0;
        n0 = n_out;
        step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (out_valid === 1'b1 && lat < 0) begin
                lat = k;
                checks++;
                if (sum !== 16'h2345) begin
                    failures++; $display("FAIL midrst_sum got %h required 2345", sum);
                end
            end
        end
        checks++;
        if (lat != 4 || n_out - n0 != 1) begin
            failures++;
            $display("FAIL midrst_stale got latency=%0d results=%0d required 4 1", lat, n_out - n0);
        end
    endtask

    initial begin
        test_reset();
        test_directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, "carry_chain");
        test_directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, "overflow");
        test_directed(16'h0005, 16'h0007, 1'b1, 1'b1, "subtract");
        test_directed(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_overflow");
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
